key_filter_multi: RTL
=====================

// Module: key_filter_multi
// PURPOSE
//  Multi-channel key debouncer, successor to the single-key 20 ms filter. Per channel it
//  synchronises an active-low key, debounces press and release separately, and emits
//  one-cycle press/release/long-press pulses plus a debounced level. Sits between the board
//  keys and the fare/mode control FSMs; one instance serves all front-panel keys.
// PARAMETERS
//  KEY_W      4           number of independent key channels (>=1)
//  CNT_MAX    1_000_000   debounce length in clocks; 20 ms at 50 MHz (>=2)
//  LONG_MAX   50_000_000  hold time in clocks, counted from key_press, for key_long (1 s) (>=2)
//  REPEAT_MAX 10_000_000  auto-repeat period in clocks; used only with KEY_FILTER_REPEAT_EN (>=2)
// PORTS
//  sys_clk     in   1      system clock
//  sys_rst     in   1      reset: asynchronous, active-high
//  key_in      in   KEY_W  raw keys, active-low (0 = pressed), asynchronous to sys_clk
//  key_press   out  KEY_W  1-cycle pulse per debounced press (and per repeat, if enabled)
//  key_release out  KEY_W  1-cycle pulse per debounced release
//  key_long    out  KEY_W  1-cycle pulse, at most once per press, after LONG_MAX hold
//  key_level   out  KEY_W  debounced state, 1 = pressed
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. On reset: 2-FF synchronisers = 1
//    (released), every FSM = IDLE, all counters = 0, all outputs = 0.
//  - Channels fully independent; no shared counter. ks = 2nd sync stage of key_in[i].
//  - Per-channel FSM (all outputs registered):
//    IDLE:    ks=0 -> PRESS_DEB, dcnt=0.
//    PRESS_DEB: ks=1 -> IDLE, dcnt=0 (bounce, no pulse). ks=0: dcnt++; on the edge where ks=0
//             has been sampled CNT_MAX consecutive times -> HELD, key_press=1, key_level=1,
//             hcnt=0.
//    HELD:    ks=1 -> RELEASE_DEB, dcnt=0. hcnt++ each edge, saturating at LONG_MAX.
//    RELEASE_DEB: ks=0 -> HELD (dcnt=0, hcnt keeps counting). ks=1 for CNT_MAX consecutive
//             edges -> IDLE, key_release=1, key_level=0, hcnt=0.
//  - Latency: key_in[i] steady low from before edge 1 -> key_press[i] high from edge CNT_MAX+2
//    for exactly one cycle. Release is symmetric: key_release one cycle, CNT_MAX+2 edges
//    after key_in returns high.
//  - key_long: one-cycle pulse on the edge hcnt reaches LONG_MAX (HELD or RELEASE_DEB),
//    i.e. LONG_MAX edges after the key_press edge; hcnt then saturates, no further pulse
//    until a new press.
//  - key_level changes only on the key_press/key_release edges; a glitch shorter than
//    CNT_MAX clocks in either state never changes key_level or produces a pulse.
//  - Counter widths $clog2(max+1); no wrap-around possible (saturation / reset only).
//  - Reset mid-press: all state cleared, no release pulse is emitted; a key still held after
//    reset deasserts is debounced again as a fresh press.
// CONFIGURATION
//  KEY_FILTER_REPEAT_EN defined: after key_long, while in HELD, key_press re-pulses every
//    REPEAT_MAX edges (first repeat REPEAT_MAX edges after key_long); repeat counter pauses
//    in RELEASE_DEB and resumes on return to HELD; cleared on IDLE.
//  KEY_FILTER_REPEAT_EN undefined: no repeat logic synthesised, key_press pulses exactly
//    once per press, REPEAT_MAX ignored.
// TESTING (KEY_W=2, CNT_MAX=4, LONG_MAX=10, REPEAT_MAX=5)
//  1 key_in[0] low from edge 1, held 8 edges, then high -> key_press[0] high after edge 6 for
//    1 cycle, key_level[0]=1; key_release[0] 1 cycle CNT_MAX+2 edges after release; no key_long.
//  2 key_in[0] low 3 cycles, high 1, low 3, high -> no key_press, key_level[0] stays 0.
//  3 key_in[1] held low 20 edges -> key_press[1] at edge 6, key_long[1] at edge 16, single
//    pulse each; with REPEAT_EN extra key_press[1] at edge 21 if still held.
//  4 held channel 0 gets a 2-cycle high glitch -> no key_release, key_level[0] stays 1.
//  5 both keys pressed same cycle -> key_press=2'b11 same cycle; channel 1 released
//    early -> only key_release[1] pulses, channel 0 unaffected.
//  6 sys_rst pulsed while key_level[0]=1 -> all outputs 0 immediately, no key_release; key
//    still low -> fresh key_press CNT_MAX+2 edges after reset release.

Source files
------------

// File: rtl/key_filter_multi.sv
// key_filter_multi: multi-channel active-low key debouncer.
// Each channel has its own 2-FF synchroniser, press/release debounce FSM and
// hold counter. Outputs are registered one-cycle pulses plus a debounced level.
// Optional feature macro: KEY_FILTER_REPEAT_EN. When defined, a held key
// auto-repeats key_press every REPEAT_MAX clocks after key_long. When it is
// undefined, no repeat logic is built and REPEAT_MAX is only range-checked.

module key_filter_chan #(
   parameter int CNT_MAX    = 1_000_000,
   parameter int LONG_MAX   = 50_000_000,
   parameter int REPEAT_MAX = 10_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_in,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_level
);
   localparam int DW = $clog2(CNT_MAX + 1);
   localparam int HW = $clog2(LONG_MAX + 1);
   // dcnt counts the samples that follow the first one, so the Nth matching
   // sample is the one that arrives while dcnt == N-2.
   localparam logic [DW-1:0] DEB_LAST = DW'(CNT_MAX - 2);
   localparam logic [HW-1:0] H_MAX    = HW'(LONG_MAX);
   localparam logic [HW-1:0] H_PRE    = HW'(LONG_MAX - 1);

   if (CNT_MAX < 2 || LONG_MAX < 2 || REPEAT_MAX < 2) begin : g_bad_param
      $error("key_filter_chan: CNT_MAX, LONG_MAX and REPEAT_MAX must be >= 2");
   end

   typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;

   state_t        state, state_nxt;
   logic [1:0]    sync;
   logic          ks;
   logic [DW-1:0] dcnt, dcnt_nxt;
   logic [HW-1:0] hcnt, hcnt_nxt, hcnt_inc;
   logic          press_nxt, release_nxt, long_nxt, level_nxt;

   assign ks       = sync[1];
   assign hcnt_inc = (hcnt == H_MAX) ? hcnt : hcnt + 1'b1;

`ifdef KEY_FILTER_REPEAT_EN
   localparam int RW = $clog2(REPEAT_MAX + 1);
   localparam logic [RW-1:0] R_LAST = RW'(REPEAT_MAX - 1);
   logic [RW-1:0] rcnt, rcnt_nxt;
`endif

   // Two-stage synchroniser; resets to the released level (1).
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) sync <= 2'b11;
      else         sync <= {sync[0], key_in};
   end

   // Debounce FSM next state, counters and output pulses.
   always_comb begin
      state_nxt   = state;
      dcnt_nxt    = dcnt;
      hcnt_nxt    = hcnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      level_nxt   = key_level;
`ifdef KEY_FILTER_REPEAT_EN
      rcnt_nxt    = rcnt;
`endif
      case (state)
         IDLE: begin
            dcnt_nxt = '0;
            hcnt_nxt = '0;
            if (!ks) state_nxt = PRESS_DEB;
         end
         PRESS_DEB: begin
            if (ks) begin
               state_nxt = IDLE;
               dcnt_nxt  = '0;
            end else if (dcnt == DEB_LAST) begin
               state_nxt = HELD;
               dcnt_nxt  = '0;
               hcnt_nxt  = '0;
               press_nxt = 1'b1;
               level_nxt = 1'b1;
            end else begin
               dcnt_nxt = dcnt + 1'b1;
            end
         end
         HELD: begin
            hcnt_nxt = hcnt_inc;
            long_nxt = (hcnt == H_PRE);
            if (ks) begin
               state_nxt = RELEASE_DEB;
               dcnt_nxt  = '0;
            end
         end
         RELEASE_DEB: begin
            hcnt_nxt = hcnt_inc;
            long_nxt = (hcnt == H_PRE);
            if (!ks) begin
               state_nxt = HELD;
               dcnt_nxt  = '0;
            end else if (dcnt == DEB_LAST) begin
               // a completed release wins over a coincident long-press edge
               state_nxt   = IDLE;
               dcnt_nxt    = '0;
               hcnt_nxt    = '0;
               long_nxt    = 1'b0;
               release_nxt = 1'b1;
               level_nxt   = 1'b0;
            end else begin
               dcnt_nxt = dcnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
`ifdef KEY_FILTER_REPEAT_EN
      // repeat timer starts at key_long and only runs while steadily held
      if (state_nxt == IDLE) begin
         rcnt_nxt = '0;
      end else if (long_nxt) begin
         rcnt_nxt = '0;
      end else if (state == HELD && !ks && hcnt == H_MAX) begin
         if (rcnt == R_LAST) begin
            rcnt_nxt  = '0;
            press_nxt = 1'b1;
         end else begin
            rcnt_nxt = rcnt + 1'b1;
         end
      end
`endif
   end

   // State, counters and registered outputs.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= IDLE;
         dcnt        <= '0;
         hcnt        <= '0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_level   <= 1'b0;
`ifdef KEY_FILTER_REPEAT_EN
         rcnt        <= '0;
`endif
      end else begin
         state       <= state_nxt;
         dcnt        <= dcnt_nxt;
         hcnt        <= hcnt_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_long    <= long_nxt;
         key_level   <= level_nxt;
`ifdef KEY_FILTER_REPEAT_EN
         rcnt        <= rcnt_nxt;
`endif
      end
   end
endmodule

module key_filter_multi #(
   parameter int KEY_W      = 4,
   parameter int CNT_MAX    = 1_000_000,
   parameter int LONG_MAX   = 50_000_000,
   parameter int REPEAT_MAX = 10_000_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] key_press,
   output logic [KEY_W-1:0] key_release,
   output logic [KEY_W-1:0] key_long,
   output logic [KEY_W-1:0] key_level
);
   for (genvar g = 0; g < KEY_W; g++) begin : g_ch
      key_filter_chan #(
         .CNT_MAX    (CNT_MAX),
         .LONG_MAX   (LONG_MAX),
         .REPEAT_MAX (REPEAT_MAX)
      ) u_chan (
         .sys_clk     (sys_clk),
         .sys_rst     (sys_rst),
         .key_in      (key_in[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g]),
         .key_long    (key_long[g]),
         .key_level   (key_level[g])
      );
   end
endmodule
